// File: rtl/ieee2int_stream_if.sv
// Stream bundle for ieee2int_stream: operand input handshake plus result/flags output handshake.
// master = producer/consumer environment, slave = converter.
interface ieee2int_stream_if #(
  parameter int unsigned DataWidth = 32
);
  logic [DataWidth-1:0] ieee_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [DataWidth-1:0] int_o;
  logic                 invalid_o;
  logic                 inexact_o;
  logic                 out_valid_o;
  logic                 out_ready_i;

  modport master (
    output ieee_i, in_valid_i, out_ready_i,
    input  in_ready_o, int_o, invalid_o, inexact_o, out_valid_o
  );

  modport slave (
    input  ieee_i, in_valid_i, out_ready_i,
    output in_ready_o, int_o, invalid_o, inexact_o, out_valid_o
  );
endinterface

// File: rtl/ieee2int_stream.sv
// Two-stage elastic IEEE 754 (binary32/binary64) to signed integer converter, truncating.
// Optional macro IEEE2INT_INEXACT_EN enables the inexact flag; otherwise inexact_o is tied low.
module ieee2int_stream #(
  parameter int unsigned DataWidth = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ieee2int_stream_if.slave   bus
);

  localparam int unsigned ExpWidth = (DataWidth == 64) ? 11 : 8;
  localparam int unsigned ManWidth = DataWidth - ExpWidth - 1;
  localparam int unsigned ShW      = $clog2(DataWidth);
  localparam int unsigned FullW    = DataWidth + ManWidth;
  localparam int unsigned BiasI    = (1 << (ExpWidth - 1)) - 1;

  localparam logic [ExpWidth-1:0] Bias   = ExpWidth'(BiasI);
  localparam logic [ExpWidth-1:0] MaxExp = ExpWidth'(BiasI + DataWidth - 2);
  localparam logic [ExpWidth-1:0] MinExp = ExpWidth'(BiasI + DataWidth - 1);

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NAN,
    CLS_SAT,
    CLS_NORM
  } cls_e;

  // Handshake control
  logic w_s2_adv;
  logic w_s1_adv;
  logic r_s1_valid;
  logic r_s2_valid;

  assign w_s2_adv       = !r_s2_valid || bus.out_ready_i;
  assign w_s1_adv       = !r_s1_valid || w_s2_adv;
  assign bus.in_ready_o = w_s1_adv;

  // Stage 1: classify
  logic                w_sign;
  logic [ExpWidth-1:0] w_exp;
  logic [ManWidth-1:0] w_man;
  cls_e                w_cls;
  logic [ShW-1:0]      w_shift;

  assign w_sign = bus.ieee_i[DataWidth-1];
  assign w_exp  = bus.ieee_i[DataWidth-2 -: ExpWidth];
  assign w_man  = bus.ieee_i[ManWidth-1:0];

`ifdef IEEE2INT_INEXACT_EN
  logic w_small_nz;
  logic r_s1_small_nz;
  assign w_small_nz = (w_exp != '0) || (|w_man);
`endif

  // Exactly -2^(DataWidth-1) is the only in-range value with exponent DataWidth-1.
  always_comb begin
    w_cls   = CLS_ZERO;
    w_shift = '0;
    if (w_exp == '1) begin
      w_cls = (|w_man) ? CLS_NAN : CLS_SAT;
    end else if (w_exp < Bias) begin
      w_cls = CLS_ZERO;
    end else if (w_exp <= MaxExp) begin
      w_cls   = CLS_NORM;
      w_shift = ShW'(w_exp - Bias);
    end else if ((w_exp == MinExp) && w_sign && !(|w_man)) begin
      w_cls   = CLS_NORM;
      w_shift = ShW'(DataWidth - 1);
    end else begin
      w_cls = CLS_SAT;
    end
  end

  logic                r_s1_sign;
  cls_e                r_s1_cls;
  logic [ManWidth-1:0] r_s1_man;
  logic [ShW-1:0]      r_s1_shift;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid    <= 1'b0;
      r_s1_sign     <= 1'b0;
      r_s1_cls      <= CLS_ZERO;
      r_s1_man      <= '0;
      r_s1_shift    <= '0;
`ifdef IEEE2INT_INEXACT_EN
      r_s1_small_nz <= 1'b0;
`endif
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        r_s1_sign     <= w_sign;
        r_s1_cls      <= w_cls;
        r_s1_man      <= w_man;
        r_s1_shift    <= w_shift;
`ifdef IEEE2INT_INEXACT_EN
        r_s1_small_nz <= w_small_nz;
`endif
      end
    end
  end

  // Stage 2: shift, negate, saturate
  logic [FullW-1:0]     w_full;
  logic [DataWidth-1:0] w_mag;
  logic [DataWidth-1:0] w_res;
  logic                 w_inv;

  assign w_full = FullW'({1'b1, r_s1_man}) << r_s1_shift;
  assign w_mag  = DataWidth'(w_full >> ManWidth);

  always_comb begin
    w_res = '0;
    w_inv = 1'b0;
    case (r_s1_cls)
      CLS_NORM: w_res = r_s1_sign ? (-w_mag) : w_mag;
      CLS_SAT: begin
        w_res = r_s1_sign ? {1'b1, {(DataWidth-1){1'b0}}} : {1'b0, {(DataWidth-1){1'b1}}};
        w_inv = 1'b1;
      end
      CLS_NAN:  w_inv = 1'b1;
      default:  w_res = '0;
    endcase
  end

`ifdef IEEE2INT_INEXACT_EN
  logic w_inx;
  logic r_inx;
  always_comb begin
    w_inx = 1'b0;
    if (r_s1_cls == CLS_ZERO)      w_inx = r_s1_small_nz;
    else if (r_s1_cls == CLS_NORM) w_inx = |w_full[ManWidth-1:0];
  end
`endif

  logic [DataWidth-1:0] r_int;
  logic                 r_inv;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid <= 1'b0;
      r_int      <= '0;
      r_inv      <= 1'b0;
`ifdef IEEE2INT_INEXACT_EN
      r_inx      <= 1'b0;
`endif
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_int <= w_res;
        r_inv <= w_inv;
`ifdef IEEE2INT_INEXACT_EN
        r_inx <= w_inx;
`endif
      end
    end
  end

  assign bus.out_valid_o = r_s2_valid;
  assign bus.int_o       = r_int;
  assign bus.invalid_o   = r_inv;
`ifdef IEEE2INT_INEXACT_EN
  assign bus.inexact_o   = r_inx;
`else
  assign bus.inexact_o   = 1'b0;
`endif

endmodule
